// File: rtl/chord_arpeggio_sequencer_pkg.sv
// Shared definitions for the chord arpeggio sequencer.
//   state_e          : playback FSM states
//   NOTE_C..NOTE_B   : pitch classes 0..11
//   chord codes      : REST (0) and the seven playable chord qualities
//   NOTES_PER_CHORD  : notes packed in one mapper word
//   norm12()         : folds a 4-bit note nibble into 0..11
package chord_arpeggio_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PLAY    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_REST    = 3'd5,
    ST_ADVANCE = 3'd6
  } state_e;

  localparam logic [3:0] NOTE_C  = 4'd0;
  localparam logic [3:0] NOTE_CS = 4'd1;
  localparam logic [3:0] NOTE_D  = 4'd2;
  localparam logic [3:0] NOTE_DS = 4'd3;
  localparam logic [3:0] NOTE_E  = 4'd4;
  localparam logic [3:0] NOTE_F  = 4'd5;
  localparam logic [3:0] NOTE_FS = 4'd6;
  localparam logic [3:0] NOTE_G  = 4'd7;
  localparam logic [3:0] NOTE_GS = 4'd8;
  localparam logic [3:0] NOTE_A  = 4'd9;
  localparam logic [3:0] NOTE_AS = 4'd10;
  localparam logic [3:0] NOTE_B  = 4'd11;

  localparam logic [3:0] REST       = 4'd0;
  localparam logic [3:0] CHORD_MAJ7 = 4'd1;
  localparam logic [3:0] CHORD_MIN7 = 4'd2;
  localparam logic [3:0] CHORD_DIM7 = 4'd3;
  localparam logic [3:0] CHORD_AUG  = 4'd4;
  localparam logic [3:0] CHORD_DOM7 = 4'd5;
  localparam logic [3:0] CHORD_SUS2 = 4'd6;
  localparam logic [3:0] CHORD_SUS4 = 4'd7;

  localparam int NOTES_PER_CHORD = 4;

  // Nibbles 12..15 are the same pitch class one octave up; fold them down.
  function automatic logic [3:0] norm12(input logic [3:0] nibble);
    logic [3:0] res;
    if (nibble >= 4'd12) begin
      res = nibble - 4'd12;
    end else begin
      res = nibble;
    end
    return res;
  endfunction

endpackage

// File: rtl/chord_arpeggio_sequencer_beat_timer.sv
// Beat / rest duration counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force count to zero (held while the timer is not in use)
//   enable     : count one per cycle
//   term       : terminal count value
//   tc         : high while enabled and count equals term
module chord_arpeggio_sequencer_beat_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] count_r;

  // Cycle counter; cleared whenever the owner state is not active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (enable) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = enable && (count_r == term);

endmodule

// File: rtl/chord_arpeggio_sequencer.sv
// Chord progression arpeggiator.
//   prog_we/prog_addr/prog_chord : progression RAM write port (codes 8..15 stored as rest)
//   key, len, loop, start, stop  : playback controls (key and len latched at start)
//   map_chord/map_key -> mapper, map_notes <- mapper one cycle later
//   note_valid/note_ready/note_out : note stream to the tone generator
//   step_idx, busy, done         : status; done pulses when a non-looping run ends
module chord_arpeggio_sequencer
  import chord_arpeggio_sequencer_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TICKS_PER_BEAT = 50000,
  parameter int NOTES          = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [3:0]               prog_chord,
  input  logic [3:0]               key,
  input  logic [3:0]               len,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic [3:0]               map_chord,
  output logic [3:0]               map_key,
  input  logic [15:0]              map_notes,
  output logic                     note_valid,
  input  logic                     note_ready,
  output logic [3:0]               note_out,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(NOTES * TICKS_PER_BEAT);
  localparam logic [TW-1:0] HOLD_TERM = TW'(TICKS_PER_BEAT - 1);
  localparam logic [TW-1:0] REST_TERM = TW'(NOTES * TICKS_PER_BEAT - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [1:0]    LAST_IDX  = 2'(NOTES_PER_CHORD - 1);

  state_e        state_r, state_nxt;
  logic [3:0]    prog_r  [DEPTH];
  logic [3:0]    notes_r [NOTES_PER_CHORD];
  logic [AW-1:0] step_r, step_nxt;
  logic [1:0]    idx_r, idx_nxt;
  logic [3:0]    key_r, key_nxt;
  logic [LW-1:0] len_r, len_nxt, len_clamp_s;
  logic [4:0]    len_ext_s;
  logic [3:0]    map_chord_r, map_chord_nxt;
  logic [3:0]    note_out_r, note_nxt;
  logic          note_valid_r, busy_r, done_r, done_nxt;
  logic          capture_s, last_step_s, timer_en_s, timer_tc_s;
  logic [TW-1:0] timer_term_s;

  assign len_ext_s   = {1'b0, len};
  assign len_clamp_s = (len_ext_s > 5'(DEPTH)) ? DEPTH_L : LW'(len_ext_s);
  assign last_step_s = (LW'(step_r) == (len_r - LW'(1)));

  // One timer serves both the per-note hold and the whole-chord rest.
  assign timer_en_s   = (state_r == ST_HOLD) || (state_r == ST_REST);
  assign timer_term_s = (state_r == ST_HOLD) ? HOLD_TERM : REST_TERM;

  chord_arpeggio_sequencer_beat_timer #(.WIDTH(TW)) u_beat_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!timer_en_s),
    .enable (timer_en_s),
    .term   (timer_term_s),
    .tc     (timer_tc_s)
  );

  // Progression RAM; intentionally not reset. Same-cycle fetch reads the old word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      prog_r[prog_addr] <= prog_chord[3] ? REST : prog_chord;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and datapath next values; stop overrides every state.
  always_comb begin
    state_nxt     = state_r;
    step_nxt      = step_r;
    idx_nxt       = idx_r;
    key_nxt       = key_r;
    len_nxt       = len_r;
    map_chord_nxt = map_chord_r;
    note_nxt      = note_out_r;
    done_nxt      = 1'b0;
    capture_s     = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (len != 4'd0)) begin
            state_nxt     = ST_FETCH;
            step_nxt      = {AW{1'b0}};
            key_nxt       = key;
            len_nxt       = len_clamp_s;
            map_chord_nxt = prog_r[{AW{1'b0}}];
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_FETCH: begin
          state_nxt = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          capture_s = 1'b1;
          idx_nxt   = 2'd0;
          if (map_chord_r == REST) begin
            state_nxt = ST_REST;
          end else begin
            state_nxt = ST_PLAY;
            note_nxt  = norm12(map_notes[15:12]);
          end
        end
        ST_PLAY: begin
          if (note_ready) begin
            state_nxt = ST_HOLD;
          end else begin
            state_nxt = ST_PLAY;
          end
        end
        ST_HOLD: begin
          if (timer_tc_s) begin
            if (idx_r != LAST_IDX) begin
              state_nxt = ST_PLAY;
              idx_nxt   = idx_r + 2'd1;
              note_nxt  = notes_r[idx_r + 2'd1];
            end else begin
              state_nxt = ST_ADVANCE;
            end
          end else begin
            state_nxt = ST_HOLD;
          end
        end
        ST_REST: begin
          if (timer_tc_s) begin
            state_nxt = ST_ADVANCE;
          end else begin
            state_nxt = ST_REST;
          end
        end
        ST_ADVANCE: begin
          if (!last_step_s) begin
            state_nxt     = ST_FETCH;
            step_nxt      = step_r + AW'(1);
            map_chord_nxt = prog_r[step_r + AW'(1)];
          end else if (loop) begin
            state_nxt     = ST_FETCH;
            step_nxt      = {AW{1'b0}};
            map_chord_nxt = prog_r[{AW{1'b0}}];
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_r       <= {AW{1'b0}};
      idx_r        <= 2'd0;
      key_r        <= 4'd0;
      len_r        <= {LW{1'b0}};
      map_chord_r  <= 4'd0;
      note_out_r   <= 4'd0;
      note_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      for (int i = 0; i < NOTES_PER_CHORD; i++) begin
        notes_r[i] <= 4'd0;
      end
    end else begin
      step_r       <= step_nxt;
      idx_r        <= idx_nxt;
      key_r        <= key_nxt;
      len_r        <= len_nxt;
      map_chord_r  <= map_chord_nxt;
      note_out_r   <= note_nxt;
      note_valid_r <= (state_nxt == ST_PLAY);
      busy_r       <= (state_nxt != ST_IDLE);
      done_r       <= done_nxt;
      if (capture_s) begin
        // Normalise once at capture so the buffer always holds 0..11.
        for (int i = 0; i < NOTES_PER_CHORD; i++) begin
          notes_r[i] <= norm12(map_notes[15-4*i -: 4]);
        end
      end
    end
  end

  assign map_chord  = map_chord_r;
  assign map_key    = key_r;
  assign note_valid = note_valid_r;
  assign note_out   = note_out_r;
  assign step_idx   = step_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule
